// File: rtl/layer1_mac_sequencer_pkg.sv
// Shared definitions for the Layer-1 MAC sequencer.
//   LANES/DATA_W/VEC_W : geometry of the 10-lane MAC array datapath.
//   ST_* localparams   : sequencer state encoding, wrapped by state_e.
//   cnt_w()            : counter width able to hold 0..maxval (min 1 bit).
package layer1_mac_sequencer_pkg;

  localparam int LANES  = 10;
  localparam int DATA_W = 16;
  localparam int VEC_W  = LANES * DATA_W;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_ACCUM_ENC = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
  localparam logic [1:0] ST_HOLD_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_ACCUM = ST_ACCUM_ENC,
    ST_DRAIN = ST_DRAIN_ENC,
    ST_HOLD  = ST_HOLD_ENC
  } state_e;

  function automatic int cnt_w(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/layer1_mac_sequencer_if.sv
// Bundle of the sequencer's three data paths:
//   input stream  : in_valid/in_ready/in_pixels/in_weight
//   array side    : mac_pixels/mac_weight/mac_clr out, mac_column in
//   output stream : out_valid/out_ready/out_column
// master = sequencer view, slave = surrounding (source, array, sink) view.
interface layer1_mac_sequencer_if;

  logic                                      in_valid;
  logic                                      in_ready;
  logic [layer1_mac_sequencer_pkg::VEC_W-1:0]  in_pixels;
  logic [layer1_mac_sequencer_pkg::DATA_W-1:0] in_weight;

  logic [layer1_mac_sequencer_pkg::VEC_W-1:0]  mac_pixels;
  logic [layer1_mac_sequencer_pkg::DATA_W-1:0] mac_weight;
  logic                                      mac_clr;
  logic [layer1_mac_sequencer_pkg::VEC_W-1:0]  mac_column;

  logic                                      out_valid;
  logic                                      out_ready;
  logic [layer1_mac_sequencer_pkg::VEC_W-1:0]  out_column;

  modport master (
    input  in_valid, in_pixels, in_weight, mac_column, out_ready,
    output in_ready, mac_pixels, mac_weight, mac_clr, out_valid, out_column
  );

  modport slave (
    output in_valid, in_pixels, in_weight, mac_column, out_ready,
    input  in_ready, mac_pixels, mac_weight, mac_clr, out_valid, out_column
  );

endinterface

// File: rtl/layer1_mac_sequencer_tap_counter.sv
// Tap counter for one dot-product vector.
//   clk, reset : clock, async active-low reset
//   clr_i      : return to 0 (highest priority)
//   load_i     : start a vector, count becomes 1
//   inc_i      : count one more tap, saturates at LIMIT
//   last_o     : count equals LIMIT-1, i.e. the next tap completes the vector
module layer1_mac_sequencer_tap_counter #(
  parameter int LIMIT = 9,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic load_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = CNT_W'(1);
    else if (inc_i && (cnt_q < CNT_W'(LIMIT)))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/layer1_mac_sequencer.sv
// Upstream control stage for the Layer-1 10-lane MAC array.
// Accepts TAPS (pixel-vector, weight) beats, steers them into the array,
// waits MAC_LAT clocks for the last product to land, then captures the
// 160-bit column and offers it downstream until accepted.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low reset
//   bus.in_*   : input beat stream (valid/ready, pixels, weight)
//   bus.mac_*  : array drive (pixels, weight, clr) and array result (column)
//   bus.out_*  : result stream (valid/ready, column)
module layer1_mac_sequencer
  import layer1_mac_sequencer_pkg::*;
#(
  parameter int TAPS    = 9,
  parameter int MAC_LAT = 1
) (
  input logic                  clk,
  input logic                  reset,
  layer1_mac_sequencer_if.master bus
);

  localparam int TAP_W = cnt_w(TAPS);
  localparam int LAT_W = cnt_w(MAC_LAT);

  state_e             state_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [VEC_W-1:0]   out_column_q;
  logic [LAT_W-1:0]   lat_cnt_q;

  logic               accept;
  logic               tap_last;

  assign accept = bus.in_valid & in_ready_q;

  // Array drive: only an accepted beat reaches the array; a zero product
  // otherwise lets the array hold its running sum.
  assign bus.mac_pixels = accept ? bus.in_pixels : '0;
  assign bus.mac_weight = accept ? bus.in_weight : '0;
  assign bus.mac_clr    = (state_q == ST_IDLE);

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_column = out_column_q;

  layer1_mac_sequencer_tap_counter #(
    .LIMIT (TAPS),
    .CNT_W (TAP_W)
  ) u_tap_counter (
    .clk    (clk),
    .reset  (reset),
    .clr_i  ((state_q == ST_HOLD) && bus.out_ready),
    .load_i (accept && (state_q == ST_IDLE)),
    .inc_i  (accept && (state_q == ST_ACCUM)),
    .last_o (tap_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_column_q <= '0;
      lat_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            if (TAPS > 1) begin
              state_q <= ST_ACCUM;
            end else begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_ACCUM: begin
          if (accept && tap_last) begin
            state_q    <= ST_DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // mac_column already reflects the last beat once MAC_LAT clocks have passed
          if (lat_cnt_q == LAT_W'(MAC_LAT)) begin
            out_column_q <= bus.mac_column;
            out_valid_q  <= 1'b1;
            lat_cnt_q    <= '0;
            state_q      <= ST_HOLD;
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_layer1_mac_sequencer.sv
// Bench for layer1_mac_sequencer (TAPS=3, MAC_LAT=1) paired with a
// behavioural 10-lane modulo-2^16 MAC array.
module tb_layer1_mac_sequencer;
  import layer1_mac_sequencer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  layer1_mac_sequencer_if bus();

  layer1_mac_sequencer #(.TAPS(3), .MAC_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // MAC array: clear loads the product, otherwise accumulate; 1 clock latency.
  function automatic logic [VEC_W-1:0] mac_next(input logic [VEC_W-1:0] acc,
                                                input logic [VEC_W-1:0] pix,
                                                input logic [DATA_W-1:0] w,
                                                input logic clr);
    logic [VEC_W-1:0] r;
    logic [31:0] prod;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      prod = {16'd0, pix[16*i +: 16]} * {16'd0, w};
      r[16*i +: 16] = clr ? prod[15:0] : acc[16*i +: 16] + prod[15:0];
    end
    return r;
  endfunction

  logic [VEC_W-1:0] acc_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= mac_next(acc_q, bus.mac_pixels, bus.mac_weight, bus.mac_clr);
  end
  assign bus.mac_column = acc_q;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] splat(input logic [15:0] v);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  function automatic logic [VEC_W-1:0] lane_scaled(input int k);
    logic [VEC_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[16*i +: 16] = 16'(i * k);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input logic [VEC_W-1:0] p, input logic [15:0] w);
    int n;
    n = 0;
    bus.in_valid  = 1'b1;
    bus.in_pixels = p;
    bus.in_weight = w;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_beat timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_pixels = '0;
    bus.in_weight = '0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic release_out(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({name, " out_valid after accept"}, VEC_W'(bus.out_valid), VEC_W'(0));
    chk({name, " in_ready after accept"},  VEC_W'(bus.in_ready),  VEC_W'(1));
  endtask

  typedef struct {
    string            name;
    logic [VEC_W-1:0] pix0, pix1, pix2;
    logic [15:0]      w0, w1, w2;
    int               gap;
    logic [VEC_W-1:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat;
    logic [VEC_W-1:0] p6;

    bus.in_valid  = 1'b0;
    bus.in_pixels = '0;
    bus.in_weight = '0;
    bus.out_ready = 1'b0;

    p6 = splat(16'd3);
    p6[15:0] = 16'h4000;

    tbl[0] = '{name:"t1_backtoback", pix0:splat(2), pix1:splat(2), pix2:splat(2),
               w0:1, w1:2, w2:3, gap:0, exp:splat(16'd12)};
    tbl[1] = '{name:"t2_stall", pix0:splat(2), pix1:splat(2), pix2:splat(2),
               w0:1, w1:2, w2:3, gap:4, exp:splat(16'd12)};
    tbl[2] = '{name:"t3a_lane_idx", pix0:lane_scaled(1), pix1:lane_scaled(1), pix2:lane_scaled(1),
               w0:1, w1:1, w2:1, gap:0, exp:lane_scaled(3)};
    tbl[3] = '{name:"t3b_clear", pix0:splat(1), pix1:splat(1), pix2:splat(1),
               w0:5, w1:5, w2:5, gap:0, exp:splat(16'd15)};
    tbl[4] = '{name:"t6_wrap", pix0:p6, pix1:p6, pix2:p6,
               w0:4, w1:0, w2:0, gap:0, exp:{splat(16'd12)} & ~{{(VEC_W-16){1'b0}}, 16'hFFFF}};

    // Reset state, with a beat offered to show nothing leaks to the array.
    #3;
    bus.in_valid  = 1'b1;
    bus.in_pixels = splat(16'h1234);
    bus.in_weight = 16'h5678;
    #1;
    chk("rst in_ready",   VEC_W'(bus.in_ready),   VEC_W'(0));
    chk("rst out_valid",  VEC_W'(bus.out_valid),  VEC_W'(0));
    chk("rst out_column", bus.out_column,         '0);
    chk("rst mac_pixels", bus.mac_pixels,         '0);
    chk("rst mac_weight", VEC_W'(bus.mac_weight), VEC_W'(0));
    chk("rst mac_clr",    VEC_W'(bus.mac_clr),    VEC_W'(1));
    bus.in_valid  = 1'b0;
    bus.in_pixels = '0;
    bus.in_weight = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 5; k++) begin
      send_beat(tbl[k].pix0, tbl[k].w0);
      repeat (tbl[k].gap) @(negedge clk);
      send_beat(tbl[k].pix1, tbl[k].w1);
      send_beat(tbl[k].pix2, tbl[k].w2);
      wait_out(lat);
      chk({tbl[k].name, " latency"}, VEC_W'(lat), VEC_W'(2));
      chk({tbl[k].name, " out_column"}, bus.out_column, tbl[k].exp);
      release_out(tbl[k].name);
    end

    // Back-pressure in HOLD: result and handshake stable, no inputs reach the array.
    send_beat(splat(1), 1);
    send_beat(splat(1), 1);
    send_beat(splat(1), 1);
    wait_out(lat);
    bus.in_valid  = 1'b1;
    bus.in_pixels = splat(16'h00FF);
    bus.in_weight = 16'd9;
    for (int c = 0; c < 6; c++) begin
      chk("t4 hold out_valid",  VEC_W'(bus.out_valid),  VEC_W'(1));
      chk("t4 hold out_column", bus.out_column,         splat(16'd3));
      chk("t4 hold in_ready",   VEC_W'(bus.in_ready),   VEC_W'(0));
      chk("t4 hold mac_weight", VEC_W'(bus.mac_weight), VEC_W'(0));
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.in_pixels = '0;
    bus.in_weight = '0;
    release_out("t4");

    // Reset mid-vector after two beats, then a clean vector.
    send_beat(splat(1), 7);
    send_beat(splat(1), 7);
    #2;
    reset = 1'b0;
    #1;
    chk("t5 rst in_ready",   VEC_W'(bus.in_ready),  VEC_W'(0));
    chk("t5 rst out_valid",  VEC_W'(bus.out_valid), VEC_W'(0));
    chk("t5 rst mac_clr",    VEC_W'(bus.mac_clr),   VEC_W'(1));
    chk("t5 rst out_column", bus.out_column,        '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_beat(splat(1), 1);
    send_beat(splat(1), 1);
    send_beat(splat(1), 1);
    wait_out(lat);
    chk("t5 latency",    VEC_W'(lat),    VEC_W'(2));
    chk("t5 out_column", bus.out_column, splat(16'd3));

    // Reset while a result is held: out_valid must drop without a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("t5 hold-rst out_valid",  VEC_W'(bus.out_valid), VEC_W'(0));
    chk("t5 hold-rst out_column", bus.out_column,        '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
